// File: rtl/eth_tx_ptp_arbiter.sv
// Round-robin arbiter that shares one Ethernet TX header/payload path among
// PORTS requesters. It records the owner of every good frame in a tag FIFO
// and steers each returned MAC TX PTP timestamp back to that owner.
module eth_tx_ptp_arbiter #(
  parameter int PORTS          = 4,
  parameter int TAG_FIFO_DEPTH = 16,
  parameter int PTP_TS_WIDTH   = 96
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PORTS-1:0]          s_eth_hdr_valid,
  output logic [PORTS-1:0]          s_eth_hdr_ready,
  input  logic [PORTS*48-1:0]       s_eth_dest_mac,
  input  logic [PORTS*48-1:0]       s_eth_src_mac,
  input  logic [PORTS*16-1:0]       s_eth_type,
  input  logic [PORTS*8-1:0]        s_eth_payload_axis_tdata,
  input  logic [PORTS-1:0]          s_eth_payload_axis_tvalid,
  input  logic [PORTS-1:0]          s_eth_payload_axis_tlast,
  input  logic [PORTS-1:0]          s_eth_payload_axis_tuser,
  output logic [PORTS-1:0]          s_eth_payload_axis_tready,
  output logic                      m_eth_hdr_valid,
  input  logic                      m_eth_hdr_ready,
  output logic [47:0]               m_eth_dest_mac,
  output logic [47:0]               m_eth_src_mac,
  output logic [15:0]               m_eth_type,
  output logic [7:0]                m_eth_payload_axis_tdata,
  output logic                      m_eth_payload_axis_tvalid,
  output logic                      m_eth_payload_axis_tlast,
  output logic                      m_eth_payload_axis_tuser,
  input  logic                      m_eth_payload_axis_tready,
  input  logic [PTP_TS_WIDTH-1:0]   s_ptp_ts_96,
  input  logic                      s_ptp_ts_valid,
  output logic                      s_ptp_ts_ready,
  output logic [PTP_TS_WIDTH-1:0]   m_ptp_ts_96,
  output logic [PORTS-1:0]          m_ptp_ts_valid,
  output logic [PORTS-1:0]          grant,
  output logic                      busy,
  output logic                      tag_fifo_full,
  output logic                      ts_orphan
);

  localparam int IDX_W = $clog2(PORTS);
  localparam int PTR_W = $clog2(TAG_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [PORTS-1:0]   grant_r, grant_nxt_s;
  logic [IDX_W-1:0]   gidx_r, gidx_nxt_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [IDX_W-1:0]   pick_s;
  logic [IDX_W:0]     cand_s;
  logic               found_s, hit_s;

  logic               hdr_valid_sel_s, tvalid_sel_s;
  logic               hdr_hs_s, last_s, push_s, pop_s, orphan_s;

  logic [IDX_W-1:0]   tag_mem_r [TAG_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   count_r;

  assign s_ptp_ts_ready = rst;
  assign grant          = grant_r;
  assign busy           = (state_r != ST_IDLE);
  assign tag_fifo_full  = (count_r == CNT_W'(TAG_FIFO_DEPTH));

  assign hdr_hs_s = (state_r == ST_HDR) && m_eth_hdr_valid && m_eth_hdr_ready;
  assign last_s   = (state_r == ST_PAYLOAD) && m_eth_payload_axis_tvalid &&
                    m_eth_payload_axis_tready && m_eth_payload_axis_tlast;
  // Frames marked bad on tlast are dropped by the MAC FIFO and never stamped.
  assign push_s   = last_s && !m_eth_payload_axis_tuser;
  assign pop_s    = s_ptp_ts_valid && (count_r != {CNT_W{1'b0}});
  assign orphan_s = s_ptp_ts_valid && (count_r == {CNT_W{1'b0}});

  // Round-robin search: first requesting port after rr_ptr, wrapping to 0.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    pick_s  = {IDX_W{1'b0}};
    cand_s  = {(IDX_W+1){1'b0}};
    for (int k = 1; k <= PORTS; k++) begin
      cand_s  = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
      cand_s  = (cand_s >= (IDX_W+1)'(PORTS)) ? (cand_s - (IDX_W+1)'(PORTS)) : cand_s;
      hit_s   = !found_s && s_eth_hdr_valid[cand_s[IDX_W-1:0]];
      pick_s  = hit_s ? cand_s[IDX_W-1:0] : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // Next-state logic: grant in IDLE, hold through header and payload.
  always_comb begin
    state_nxt_s  = state_r;
    grant_nxt_s  = grant_r;
    gidx_nxt_s   = gidx_r;
    rr_ptr_nxt_s = rr_ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s && !tag_fifo_full) begin
          state_nxt_s = ST_HDR;
          gidx_nxt_s  = pick_s;
          grant_nxt_s = PORTS'(1) << pick_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (hdr_hs_s) begin
          state_nxt_s = ST_PAYLOAD;
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_PAYLOAD: begin
        if (last_s) begin
          state_nxt_s  = ST_IDLE;
          grant_nxt_s  = {PORTS{1'b0}};
          rr_ptr_nxt_s = gidx_r;
        end else begin
          state_nxt_s = ST_PAYLOAD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = {PORTS{1'b0}};
      end
    endcase
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      grant_r  <= {PORTS{1'b0}};
      gidx_r   <= {IDX_W{1'b0}};
      rr_ptr_r <= IDX_W'(PORTS - 1);
    end else begin
      state_r  <= state_nxt_s;
      grant_r  <= grant_nxt_s;
      gidx_r   <= gidx_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // AND-OR mux of the granted port; zero grant yields all-zero outputs.
  always_comb begin
    m_eth_dest_mac           = 48'd0;
    m_eth_src_mac            = 48'd0;
    m_eth_type               = 16'd0;
    m_eth_payload_axis_tdata = 8'd0;
    m_eth_payload_axis_tlast = 1'b0;
    m_eth_payload_axis_tuser = 1'b0;
    hdr_valid_sel_s          = 1'b0;
    tvalid_sel_s             = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      m_eth_dest_mac           = m_eth_dest_mac | (s_eth_dest_mac[i*48 +: 48] & {48{grant_r[i]}});
      m_eth_src_mac            = m_eth_src_mac  | (s_eth_src_mac[i*48 +: 48]  & {48{grant_r[i]}});
      m_eth_type               = m_eth_type     | (s_eth_type[i*16 +: 16]     & {16{grant_r[i]}});
      m_eth_payload_axis_tdata = m_eth_payload_axis_tdata |
                                 (s_eth_payload_axis_tdata[i*8 +: 8] & {8{grant_r[i]}});
      m_eth_payload_axis_tlast = m_eth_payload_axis_tlast | (s_eth_payload_axis_tlast[i] & grant_r[i]);
      m_eth_payload_axis_tuser = m_eth_payload_axis_tuser | (s_eth_payload_axis_tuser[i] & grant_r[i]);
      hdr_valid_sel_s          = hdr_valid_sel_s | (s_eth_hdr_valid[i] & grant_r[i]);
      tvalid_sel_s             = tvalid_sel_s    | (s_eth_payload_axis_tvalid[i] & grant_r[i]);
    end
    m_eth_hdr_valid           = (state_r == ST_HDR) && hdr_valid_sel_s;
    m_eth_payload_axis_tvalid = (state_r == ST_PAYLOAD) && tvalid_sel_s;
    s_eth_hdr_ready           = grant_r & {PORTS{(state_r == ST_HDR) && m_eth_hdr_ready}};
    s_eth_payload_axis_tready = grant_r & {PORTS{(state_r == ST_PAYLOAD) && m_eth_payload_axis_tready}};
  end

  // Tag FIFO: one entry per good frame, popped by each returned timestamp.
  // Pop reads the old head, so a same-cycle push and pop keeps order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < TAG_FIFO_DEPTH; i++) begin
        tag_mem_r[i] <= {IDX_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= gidx_r;
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered timestamp delivery and orphan flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptp_ts_96    <= {PTP_TS_WIDTH{1'b0}};
      m_ptp_ts_valid <= {PORTS{1'b0}};
      ts_orphan      <= 1'b0;
    end else begin
      if (pop_s) begin
        m_ptp_ts_96    <= s_ptp_ts_96;
        m_ptp_ts_valid <= PORTS'(1) << tag_mem_r[rd_ptr_r];
      end else begin
        m_ptp_ts_96    <= m_ptp_ts_96;
        m_ptp_ts_valid <= {PORTS{1'b0}};
      end
      ts_orphan <= orphan_s;
    end
  end

endmodule

// File: tb/tb_eth_tx_ptp_arbiter.sv
// Directed bench for eth_tx_ptp_arbiter: a vector table of frames and
// timestamp returns, plus hand-written sequences for FIFO-full, same-cycle
// push/pop and reset in the middle of a payload.
module tb_eth_tx_ptp_arbiter;

  localparam int P  = 4;
  localparam int TW = 96;
  localparam logic [TW-1:0] TS_LAST = 96'hF00D_0000_0000_0000_0000_0077;

  logic              clk = 1'b0;
  logic              rst;
  logic [P-1:0]      s_hdr_valid, s_hdr_ready;
  logic [P*48-1:0]   s_dest, s_src;
  logic [P*16-1:0]   s_type;
  logic [P*8-1:0]    s_tdata;
  logic [P-1:0]      s_tvalid, s_tlast, s_tuser, s_tready;
  logic              m_hdr_valid, m_hdr_ready;
  logic [47:0]       m_dest, m_src;
  logic [15:0]       m_type;
  logic [7:0]        m_tdata;
  logic              m_tvalid, m_tlast, m_tuser, m_tready;
  logic [TW-1:0]     s_ts, m_ts;
  logic              s_ts_valid, s_ts_ready;
  logic [P-1:0]      m_ts_valid, grant;
  logic              busy, full, orphan;

  int n_cmp = 0;
  int n_fail = 0;

  eth_tx_ptp_arbiter #(.PORTS(P), .TAG_FIFO_DEPTH(16), .PTP_TS_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tvalid(s_tvalid),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .s_eth_payload_axis_tready(s_tready),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tvalid(m_tvalid),
    .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
    .m_eth_payload_axis_tready(m_tready),
    .s_ptp_ts_96(s_ts), .s_ptp_ts_valid(s_ts_valid), .s_ptp_ts_ready(s_ts_ready),
    .m_ptp_ts_96(m_ts), .m_ptp_ts_valid(m_ts_valid),
    .grant(grant), .busy(busy), .tag_fifo_full(full), .ts_orphan(orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_ts;
    logic [P-1:0]  mask;
    int            port;
    int            len;
    bit            bad;
    logic [P-1:0]  exp_grant;
    logic [TW-1:0] ts;
    logic [P-1:0]  exp_ts;
    bit            exp_orph;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_fr(input logic [P-1:0] mask, input int port, input int len, input bit bad,
                        input logic [P-1:0] eg);
    vec_t v;
    v = '{1'b0, mask, port, len, bad, eg, '0, '0, 1'b0};
    vecs.push_back(v);
  endtask

  task automatic add_ts(input logic [TW-1:0] ts, input logic [P-1:0] ets, input bit eo);
    vec_t v;
    v = '{1'b1, '0, 0, 0, 1'b0, '0, ts, ets, eo};
    vecs.push_back(v);
  endtask

  // Timestamp in for one cycle, check the registered result and its pulse width.
  task automatic ts_return(input logic [TW-1:0] val, input logic [P-1:0] exp_v, input bit exp_o);
    s_ts = val;
    s_ts_valid = 1'b1;
    step();
    s_ts_valid = 1'b0;
    chk("ts_valid", m_ts_valid, exp_v);
    chk("ts_orphan", orphan, exp_o);
    if (exp_v != '0) chk("ts_value", m_ts, val);
    step();
    chk("ts_pulse_end", {m_ts_valid, orphan}, '0);
  endtask

  // Request with mask, expect port to win, then send a len-beat payload.
  task automatic run_frame(input int port, input int len, input bit bad, input logic [P-1:0] exp_grant,
                           input logic [P-1:0] mask, input bit ts_on_last, input logic [P-1:0] exp_ts,
                           output int lat);
    int waited;
    int badbeats;
    bit got;
    bit last;
    logic [P-1:0] oh;
    oh = P'(1) << port;
    s_hdr_valid = mask;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 20) begin
      step();
      waited++;
      if (grant != '0) got = 1'b1;
    end
    lat = waited;
    chk("grant_wait", got, 1'b1);
    if (!got) begin
      s_hdr_valid = '0;
      return;
    end
    chk("grant", grant, exp_grant);
    chk("busy", busy, 1'b1);
    chk("m_hdr_valid", m_hdr_valid, 1'b1);
    chk("s_hdr_ready", s_hdr_ready, oh);
    chk("hdr_fields", {m_dest, m_src, m_type}, {s_dest[port*48 +: 48], s_src[port*48 +: 48], s_type[port*16 +: 16]});
    step();
    s_hdr_valid = mask & ~oh;
    badbeats = 0;
    for (int b = 0; b < len; b++) begin
      last = (b == len - 1);
      s_tdata = {P{8'hEE}};
      s_tdata[port*8 +: 8] = 8'(b + 64 * port);
      s_tvalid = oh;
      s_tlast = last ? oh : '0;
      s_tuser = (last && bad) ? oh : '0;
      s_ts = TS_LAST;
      s_ts_valid = last && ts_on_last;
      #1;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'(b + 64 * port) || m_tlast !== last ||
          m_tuser !== (last && bad) || s_tready !== oh) badbeats++;
      step();
    end
    s_tvalid = '0;
    s_tlast = '0;
    s_tuser = '0;
    s_ts_valid = 1'b0;
    s_hdr_valid = '0;
    chk("payload_beats", badbeats, 0);
    chk("idle_after_tlast", {busy, grant}, '0);
    if (ts_on_last) begin
      chk("ts_on_last_valid", m_ts_valid, exp_ts);
      chk("ts_on_last_value", m_ts, TS_LAST);
    end
  endtask

  initial begin
    int lat;
    vec_t v;
    rst = 1'b0;
    s_hdr_valid = '0; s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    s_ts = '0; s_ts_valid = 1'b0; m_hdr_ready = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < P; i++) begin
      s_dest[i*48 +: 48] = 48'hD0D0_0000_0000 + 48'(i);
      s_src[i*48 +: 48]  = 48'h5A5A_0000_0000 + 48'(i);
      s_type[i*16 +: 16] = 16'h8800 + 16'(i);
    end

    // Vector table: tests 1, 2, 3 and the empty-FIFO orphan.
    add_fr(4'b0010, 1, 64, 1'b0, 4'b0010);
    add_ts(96'h0000_0000_0000_0000_0000_ABCD, 4'b0010, 1'b0);
    add_fr(4'b1000, 3, 4, 1'b0, 4'b1000);
    add_ts(96'h0000_0000_0000_0000_0000_1234, 4'b1000, 1'b0);
    for (int k = 0; k < 12; k++) add_fr(4'b1111, k % 4, 1 + (k % 3), 1'b0, 4'(1 << (k % 4)));
    for (int k = 0; k < 12; k++) add_ts(96'h1000 + 96'(k), 4'(1 << (k % 4)), 1'b0);
    add_fr(4'b0100, 2, 5, 1'b1, 4'b0100);
    add_fr(4'b1000, 3, 3, 1'b0, 4'b1000);
    add_ts(96'h0000_0000_0000_0000_0000_3333, 4'b1000, 1'b0);
    add_ts(96'h0000_0000_0000_0000_0000_DEAD, 4'b0000, 1'b1);

    // Reset state.
    step();
    step();
    chk("rst_outputs", {grant, busy, full, orphan, m_ts_valid, m_hdr_valid, m_tvalid, s_ts_ready,
                        s_hdr_ready, s_tready}, '0);
    chk("rst_ts", m_ts, '0);
    rst = 1'b1;
    step();
    chk("ts_ready_out_of_rst", s_ts_ready, 1'b1);
    chk("idle_after_rst", {grant, busy, full}, '0);

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.is_ts) ts_return(v.ts, v.exp_ts, v.exp_orph);
      else run_frame(v.port, v.len, v.bad, v.exp_grant, v.mask, 1'b0, '0, lat);
    end

    // Test 4: fill the tag FIFO, 17th request waits until one timestamp returns.
    for (int k = 0; k < 16; k++) run_frame(0, 2, 1'b0, 4'b0001, 4'b0001, 1'b0, '0, lat);
    chk("fifo_full", full, 1'b1);
    s_hdr_valid = 4'b0001;
    for (int k = 0; k < 4; k++) step();
    chk("no_grant_when_full", {grant, busy}, '0);
    s_ts = 96'h4444;
    s_ts_valid = 1'b1;
    step();
    s_ts_valid = 1'b0;
    chk("full_pop_valid", m_ts_valid, 4'b0001);
    chk("full_cleared", full, 1'b0);
    chk("grant_not_yet", grant, 4'b0000);
    step();
    chk("grant_after_pop", grant, 4'b0001);
    step();
    s_hdr_valid = '0;
    s_tdata = 8'h00; s_tvalid = 4'b0001; s_tlast = 4'b0001;
    step();
    s_tvalid = '0; s_tlast = '0;
    chk("refull", full, 1'b1);
    for (int k = 0; k < 16; k++) ts_return(96'h5000 + 96'(k), 4'b0001, 1'b0);
    ts_return(96'h6000, 4'b0000, 1'b1);

    // Test 5: pop on the same cycle as a tlast push keeps count and order.
    run_frame(1, 3, 1'b0, 4'b0010, 4'b0010, 1'b0, '0, lat);
    run_frame(2, 3, 1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0010, lat);
    ts_return(96'h7777, 4'b0100, 1'b0);
    ts_return(96'h7778, 4'b0000, 1'b1);

    // Test 6: reset at payload beat 10 with a tag outstanding.
    run_frame(3, 2, 1'b0, 4'b1000, 4'b1000, 1'b0, '0, lat);
    s_hdr_valid = 4'b0001;
    step();
    chk("t6_grant", grant, 4'b0001);
    step();
    s_hdr_valid = '0;
    for (int b = 0; b < 10; b++) begin
      s_tvalid = 4'b0001; s_tlast = '0; s_tdata = 32'(b);
      step();
    end
    s_tvalid = 4'b0001;
    #1;
    chk("t6_mid_payload", {busy, m_tvalid}, 2'b11);
    rst = 1'b0;
    #1;
    chk("t6_rst_outputs", {grant, busy, full, orphan, m_ts_valid, m_hdr_valid, m_tvalid, s_ts_ready,
                           s_hdr_ready, s_tready}, '0);
    s_tvalid = '0;
    step();
    rst = 1'b1;
    step();
    ts_return(96'h8888, 4'b0000, 1'b1);
    run_frame(0, 2, 1'b0, 4'b0001, 4'b0001, 1'b0, '0, lat);
    chk("t6_hdr_latency", lat, 1);
    ts_return(96'h9999, 4'b0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
